lsd_buffer_reader: RTL and testbench
====================================

// Module: lsd_buffer_reader
// PURPOSE
//  Read side of the Simple-LSD result buffer. On request, freezes the buffer (write protect),
//  fetches every stored segment by address and streams it out as a 64-bit AXI-Stream frame
//  (one beat per segment, TLAST on final beat) toward the DMA/PS. Sits beside image_processor,
//  driving its lsdbuf_addr/write_protect inputs and consuming its lsdbuf_* outputs.
// PARAMETERS
//  FRAME_HEIGHT  -1    vertical frame size; coordinate width VW = $clog2(FRAME_HEIGHT)
//  FRAME_WIDTH   -1    horizontal frame size; coordinate width HW = $clog2(FRAME_WIDTH)
//  RAM_SIZE      4096  buffer depth; AW = $clog2(RAM_SIZE)
//  RD_LATENCY    1     cycles from addr change to valid buffer data (>=1)
// PORTS
//  clock                    in   1    single clock
//  n_rst                    in   1    async active-low reset
//  in_start                 in   1    one-cycle read request
//  in_lsdbuf_ready          in   1    buffer holds a complete frame
//  in_lsdbuf_line_num       in   AW   number of stored segments
//  in_lsdbuf_start_v/end_v  in   VW   segment endpoints, vertical
//  in_lsdbuf_start_h/end_h  in   HW   segment endpoints, horizontal
//  out_lsdbuf_addr          out  AW   buffer read address
//  out_lsdbuf_write_protect out  1    freezes buffer contents while high
//  m_tdata                  out  64   {start_v,end_v,start_h,end_h}, each zero-extended to 16b
//  m_tvalid / m_tlast       out  1    AXI-Stream master valid / last
//  m_tready                 in   1    AXI-Stream sink ready
//  out_busy                 out  1    high from leaving IDLE until DONE completes
//  out_done                 out  1    one-cycle pulse at end of transfer
// BEHAVIOUR
//  - Reset (async, n_rst=0): state IDLE, pending=0, all outputs 0 (addr=0, protect=0, tvalid=0).
//  - in_start sets pending; pending held until consumed. in_start while busy is ignored.
//  - IDLE: pending & in_lsdbuf_ready -> LOCK, clear pending, assert write_protect (registered).
//  - LOCK: 2 cycles; line_num captured into cnt at LOCK exit. cnt==0 -> HEADER/DONE, else FETCH.
//  - FETCH: addr=idx (idx from 0); wait RD_LATENCY cycles; register fields into tdata -> SEND.
//  - SEND: tvalid=1, tdata/tlast stable until tready. Beat accepted on tvalid&tready;
//    tlast = (idx==cnt-1). On accept: idx==cnt-1 -> DONE, else idx++ -> FETCH.
//  - DONE: write_protect=0, out_done=1 for one cycle, busy=0 next cycle -> IDLE.
//  - Throughput: one beat per RD_LATENCY+2 cycles when tready held high.
//  - tvalid never deasserts before acceptance; tdata never changes while tvalid&!tready.
//  - Zero segments (no header): no beat issued; done pulse still generated.
//  - cnt max RAM_SIZE-1 (AW-bit count); idx never wraps.
//  - write_protect held continuously LOCK..SEND; buffer changes ignored meanwhile.
//  - Reset mid-transfer: stream aborted (tvalid drops async), protect released, no done pulse.
// CONFIGURATION
//  LSD_READER_HEADER_EN defined: HEADER state between LOCK and FETCH emits one beat
//    tdata={16'hA5A5, 32'd0, 16'(cnt)}; tlast on header iff cnt==0. Frame length cnt+1 beats.
//  Undefined: no HEADER state, frame length cnt beats, zero-count frame emits nothing.
// STRUCTURE
//  Shared package lsd_pkg: state enum (IDLE,LOCK,HEADER,FETCH,SEND,DONE), HEADER_MAGIC=16'hA5A5,
//  field width 16, segment struct {start_v,end_v,start_h,end_h}. One sub-module natural:
//  axis_out_reg (tdata/tvalid/tlast holding register with tready handshake).
// TESTING
//  1. line_num=3, entries preloaded, tready=1, start -> 3 beats addr 0,1,2, tlast on 3rd, done x1.
//  2. Same with tready toggled 1010..., stall 4 cycles mid-beat -> tdata/tvalid held, no loss.
//  3. line_num=0, start -> no beats (header-only beat tlast=1 if HEADER_EN), done pulse, protect 1->0.
//  4. start while ready=0, ready rises 10 cycles later -> transfer begins; start while busy ignored.
//  5. n_rst low during 2nd beat -> tvalid=0, protect=0 immediately; next start reads from addr 0.
//  6. RD_LATENCY=3, line_num=2 -> each tdata matches entry at its addr; 5-cycle beat spacing.

Source files
------------

// File: rtl/lsd_pkg.sv
// Shared types and constants for the Simple-LSD result-buffer read path.
package lsd_pkg;

    localparam int FIELD_W = 16;
    localparam logic [FIELD_W-1:0] HEADER_MAGIC = 16'hA5A5;

    typedef enum logic [2:0] {
        IDLE,
        LOCK,
        HEADER,
        FETCH,
        SEND,
        DONE
    } lsd_state_t;

    // One stored line segment as it appears on the stream, MSB first.
    typedef struct packed {
        logic [FIELD_W-1:0] start_v;
        logic [FIELD_W-1:0] end_v;
        logic [FIELD_W-1:0] start_h;
        logic [FIELD_W-1:0] end_h;
    } lsd_segment_t;

    // Frame header beat: magic, reserved zeros, segment count.
    function automatic logic [63:0] header_word(input logic [FIELD_W-1:0] count);
        return {HEADER_MAGIC, 32'd0, count};
    endfunction

endpackage

// File: rtl/lsd_buffer_reader_axis_out_reg.sv
// AXI-Stream output holding register: a loaded beat stays on tdata/tlast with
// tvalid high until the sink accepts it.
module axis_out_reg (
    input  logic        clock,
    input  logic        n_rst,
    input  logic        load,
    input  logic [63:0] load_data,
    input  logic        load_last,
    input  logic        tready,
    output logic [63:0] tdata,
    output logic        tvalid,
    output logic        tlast,
    output logic        accept
);

    assign accept = tvalid & tready;

    // Capture a new beat on load; drop valid only once the sink has taken it.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            tdata  <= '0;
            tvalid <= 1'b0;
            tlast  <= 1'b0;
        end else if (load) begin
            tdata  <= load_data;
            tlast  <= load_last;
            tvalid <= 1'b1;
        end else if (accept) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/lsd_buffer_reader.sv
// Read side of the Simple-LSD result buffer: freezes the buffer, walks every
// stored segment by address and streams it out as one 64-bit AXI-Stream frame.
// Optional build macro LSD_READER_HEADER_EN prepends a header beat
// {A5A5, 32'd0, count} to every frame.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a pending request and a complete buffer
// LOCK   | write protect raised, two cycles for the buffer to settle
// HEADER | header beat on the stream (LSD_READER_HEADER_EN only)
// FETCH  | address driven, counting down the buffer read latency
// SEND   | segment beat on the stream, waiting for acceptance
// DONE   | protect released, done pulse, back to IDLE
module lsd_buffer_reader
    import lsd_pkg::*;
#(
    parameter int FRAME_HEIGHT = 480,
    parameter int FRAME_WIDTH  = 640,
    parameter int RAM_SIZE     = 4096,
    parameter int RD_LATENCY   = 1,
    localparam int VW = $clog2(FRAME_HEIGHT),
    localparam int HW = $clog2(FRAME_WIDTH),
    localparam int AW = $clog2(RAM_SIZE)
) (
    input  logic          clock,
    input  logic          n_rst,
    input  logic          in_start,
    input  logic          in_lsdbuf_ready,
    input  logic [AW-1:0] in_lsdbuf_line_num,
    input  logic [VW-1:0] in_lsdbuf_start_v,
    input  logic [VW-1:0] in_lsdbuf_end_v,
    input  logic [HW-1:0] in_lsdbuf_start_h,
    input  logic [HW-1:0] in_lsdbuf_end_h,
    output logic [AW-1:0] out_lsdbuf_addr,
    output logic          out_lsdbuf_write_protect,
    output logic [63:0]   m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic          out_busy,
    output logic          out_done
);

    localparam int LAT_W = $clog2(RD_LATENCY + 1);

    lsd_state_t    state;
    logic          pending;
    logic          lock_cnt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] idx;
    logic [AW-1:0] last_idx;
    logic [LAT_W-1:0] lat_cnt;
    logic [AW-1:0] addr;
    logic          protect;
    logic          busy;
    logic          done;

    logic          load;
    logic [63:0]   load_data;
    logic          load_last;
    logic          accept;
    lsd_segment_t  fetched;

    assign last_idx = cnt - AW'(1);

    assign fetched.start_v = FIELD_W'(in_lsdbuf_start_v);
    assign fetched.end_v   = FIELD_W'(in_lsdbuf_end_v);
    assign fetched.start_h = FIELD_W'(in_lsdbuf_start_h);
    assign fetched.end_h   = FIELD_W'(in_lsdbuf_end_h);

    // Pick what goes into the stream register and when: buffer data once the
    // read latency has elapsed, or the header as LOCK hands over.
    always_comb begin
        load      = 1'b0;
        load_data = fetched;
        load_last = (idx == last_idx);
        if (state == FETCH && lat_cnt == '0) begin
            load = 1'b1;
        end
`ifdef LSD_READER_HEADER_EN
        if (state == LOCK && lock_cnt) begin
            load      = 1'b1;
            load_data = header_word(FIELD_W'(in_lsdbuf_line_num));
            load_last = (in_lsdbuf_line_num == '0);
        end
`endif
    end

    // Transfer sequencer: request latch, buffer lock, per-segment fetch/send walk.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            pending  <= 1'b0;
            lock_cnt <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            lat_cnt  <= '0;
            addr     <= '0;
            protect  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending && in_lsdbuf_ready) begin
                        state    <= LOCK;
                        pending  <= 1'b0;
                        protect  <= 1'b1;
                        busy     <= 1'b1;
                        lock_cnt <= 1'b0;
                    end else if (in_start) begin
                        pending <= 1'b1;
                    end
                end

                LOCK: begin
                    if (!lock_cnt) begin
                        lock_cnt <= 1'b1;
                    end else begin
                        cnt  <= in_lsdbuf_line_num;
                        idx  <= '0;
                        addr <= '0;
`ifdef LSD_READER_HEADER_EN
                        state <= HEADER;
`else
                        if (in_lsdbuf_line_num == '0) begin
                            state   <= DONE;
                            protect <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state   <= FETCH;
                            lat_cnt <= LAT_W'(RD_LATENCY);
                        end
`endif
                    end
                end

`ifdef LSD_READER_HEADER_EN
                HEADER: begin
                    if (accept) begin
                        if (cnt == '0) begin
                            state   <= DONE;
                            protect <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state   <= FETCH;
                            addr    <= '0;
                            lat_cnt <= LAT_W'(RD_LATENCY);
                        end
                    end
                end
`endif

                FETCH: begin
                    if (lat_cnt == '0) begin
                        state <= SEND;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end

                SEND: begin
                    if (accept) begin
                        if (idx == last_idx) begin
                            state   <= DONE;
                            protect <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state   <= FETCH;
                            idx     <= idx + AW'(1);
                            addr    <= idx + AW'(1);
                            lat_cnt <= LAT_W'(RD_LATENCY);
                        end
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    axis_out_reg u_axis_out (
        .clock     (clock),
        .n_rst     (n_rst),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .tready    (m_tready),
        .tdata     (m_tdata),
        .tvalid    (m_tvalid),
        .tlast     (m_tlast),
        .accept    (accept)
    );

    assign out_lsdbuf_addr          = addr;
    assign out_lsdbuf_write_protect = protect;
    assign out_busy                 = busy;
    assign out_done                 = done;

endmodule

// File: tb/tb_lsd_buffer_reader.sv
module tb_lsd_buffer_reader;
    localparam int FH = 480;
    localparam int FW = 640;
    localparam int RS = 16;
    localparam int RL = 3;
    localparam int AW = $clog2(RS);
    localparam int VW = $clog2(FH);
    localparam int HW = $clog2(FW);
`ifdef LSD_READER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic          clock = 1'b0;
    logic          n_rst;
    logic          in_start;
    logic          in_lsdbuf_ready;
    logic [AW-1:0] in_lsdbuf_line_num;
    logic [VW-1:0] in_lsdbuf_start_v;
    logic [VW-1:0] in_lsdbuf_end_v;
    logic [HW-1:0] in_lsdbuf_start_h;
    logic [HW-1:0] in_lsdbuf_end_h;
    logic [AW-1:0] out_lsdbuf_addr;
    logic          out_lsdbuf_write_protect;
    logic [63:0]   m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic          out_busy;
    logic          out_done;

    int checks = 0;
    int errors = 0;

    // buffer model: contents plus an RL-stage read pipeline
    logic [63:0] mem [RS];
    logic [63:0] pipe [RL];
    logic [63:0] rd_word;

    // results of one transfer
    logic [63:0] got_data[$];
    logic        got_last[$];
    int          got_cyc[$];
    logic [63:0] exp_data[$];
    logic        exp_last[$];
    int n_done, n_stall_viol, n_prot_viol;
    bit prot_seen, busy_early, timed_out;

    always #5 clock = ~clock;

    lsd_buffer_reader #(
        .FRAME_HEIGHT(FH), .FRAME_WIDTH(FW), .RAM_SIZE(RS), .RD_LATENCY(RL)
    ) dut (
        .clock                    (clock),
        .n_rst                    (n_rst),
        .in_start                 (in_start),
        .in_lsdbuf_ready          (in_lsdbuf_ready),
        .in_lsdbuf_line_num       (in_lsdbuf_line_num),
        .in_lsdbuf_start_v        (in_lsdbuf_start_v),
        .in_lsdbuf_end_v          (in_lsdbuf_end_v),
        .in_lsdbuf_start_h        (in_lsdbuf_start_h),
        .in_lsdbuf_end_h          (in_lsdbuf_end_h),
        .out_lsdbuf_addr          (out_lsdbuf_addr),
        .out_lsdbuf_write_protect (out_lsdbuf_write_protect),
        .m_tdata                  (m_tdata),
        .m_tvalid                 (m_tvalid),
        .m_tlast                  (m_tlast),
        .m_tready                 (m_tready),
        .out_busy                 (out_busy),
        .out_done                 (out_done)
    );

    always @(posedge clock) begin
        pipe[0] <= mem[out_lsdbuf_addr];
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end

    assign rd_word           = pipe[RL-1];
    assign in_lsdbuf_start_v = rd_word[48 +: VW];
    assign in_lsdbuf_end_v   = rd_word[32 +: VW];
    assign in_lsdbuf_start_h = rd_word[16 +: HW];
    assign in_lsdbuf_end_h   = rd_word[0  +: HW];

    task automatic fill_mem();
        for (int i = 0; i < RS; i++)
            mem[i] = {16'($urandom_range(0, FH-1)), 16'($urandom_range(0, FH-1)),
                      16'($urandom_range(0, FW-1)), 16'($urandom_range(0, FW-1))};
    endtask

    // Expected frame: optional header, then segments 0..n-1, last flag on final beat.
    function automatic void build_expected(input int n);
        exp_data.delete();
        exp_last.delete();
        if (HDR == 1) begin
            exp_data.push_back({16'hA5A5, 32'd0, 16'(n)});
            exp_last.push_back(n == 0);
        end
        for (int i = 0; i < n; i++) begin
            exp_data.push_back(mem[i]);
            exp_last.push_back(i == n - 1);
        end
    endfunction

    // Pulse start, run the stream with the given tready pattern, collect beats
    // until a few cycles past the done pulse. mode 0: ready high, 1: toggling
    // with a 4-cycle stall on the 2nd beat, 2: random.
    task automatic do_transfer(input int mode, input int ready_delay, input int restart_at);
        int k, post, stall_left;
        logic pv, pr, pl;
        logic [63:0] pd;
        got_data.delete(); got_last.delete(); got_cyc.delete();
        n_done = 0; n_stall_viol = 0; n_prot_viol = 0;
        prot_seen = 0; busy_early = 0; timed_out = 0;
        k = 0; post = -1; stall_left = 4;
        pv = 0; pr = 0; pl = 0; pd = '0;
        in_start = 1'b1;
        in_lsdbuf_ready = (ready_delay == 0);
        while (post != 0) begin
            @(posedge clock); #1;
            k++;
            in_start = (k == restart_at);
            in_lsdbuf_ready = (k >= ready_delay);
            case (mode)
                0: m_tready = 1'b1;
                1: begin
                    if (got_data.size() == 1 && m_tvalid && stall_left > 0) begin
                        m_tready = 1'b0;
                        stall_left--;
                    end else begin
                        m_tready = (k % 2 == 0);
                    end
                end
                default: m_tready = ($urandom_range(0, 3) != 0);
            endcase
            if (k < ready_delay && out_busy) busy_early = 1;
            if (pv && !pr && (!m_tvalid || m_tdata !== pd || m_tlast !== pl)) n_stall_viol++;
            if (m_tvalid && !out_lsdbuf_write_protect) n_prot_viol++;
            if (out_lsdbuf_write_protect) prot_seen = 1;
            if (m_tvalid && m_tready) begin
                got_data.push_back(m_tdata);
                got_last.push_back(m_tlast);
                got_cyc.push_back(k);
            end
            if (out_done) begin
                n_done++;
                if (post < 0) post = 4;
            end
            pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast;
            if (post > 0) post--;
            if (k > 800 && post < 0) begin
                timed_out = 1;
                post = 0;
            end
        end
        in_start = 1'b0;
        m_tready = 1'b1;
        in_lsdbuf_ready = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; in_start = 1'b0; in_lsdbuf_ready = 1'b1;
        in_lsdbuf_line_num = '0; m_tready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_stream: got v=%b l=%b d=%h expected 0/0/0", m_tvalid, m_tlast, m_tdata);
        end
        checks++;
        if (out_lsdbuf_addr !== '0 || out_lsdbuf_write_protect !== 1'b0 ||
            out_busy !== 1'b0 || out_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got addr=%0d prot=%b busy=%b done=%b expected all 0",
                     out_lsdbuf_addr, out_lsdbuf_write_protect, out_busy, out_done);
        end
        n_rst = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        fill_mem();
        in_lsdbuf_line_num = AW'(3);
        build_expected(3);
        do_transfer(0, 0, -1);
        checks++;
        if (timed_out) begin errors++; $display("FAIL basic_timeout: got no done, expected done"); end
        checks++;
        if (got_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL basic_len: got %0d beats expected %0d", got_data.size(), exp_data.size());
        end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL basic_beat%0d: got %h/%b expected %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        for (int i = HDR + 1; i < got_cyc.size(); i++) begin
            checks++;
            if (got_cyc[i] - got_cyc[i-1] != RL + 2) begin
                errors++;
                $display("FAIL basic_spacing%0d: got %0d cycles expected %0d", i, got_cyc[i] - got_cyc[i-1], RL + 2);
            end
        end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL basic_done: got %0d pulses expected 1", n_done); end
        checks++;
        if (n_prot_viol != 0 || out_lsdbuf_write_protect !== 1'b0 || out_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_protect: got viol=%0d prot=%b busy=%b expected 0/0/0", n_prot_viol, out_lsdbuf_write_protect, out_busy);
        end
    endtask

    task automatic test_backpressure();
        fill_mem();
        in_lsdbuf_line_num = AW'(3);
        build_expected(3);
        do_transfer(1, 0, -1);
        checks++;
        if (timed_out) begin errors++; $display("FAIL bp_timeout: got no done, expected done"); end
        checks++;
        if (n_stall_viol != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d changes while stalled expected 0", n_stall_viol);
        end
        checks++;
        if (got_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL bp_len: got %0d beats expected %0d", got_data.size(), exp_data.size());
        end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h/%b expected %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL bp_done: got %0d pulses expected 1", n_done); end
    endtask

    task automatic test_zero();
        in_lsdbuf_line_num = '0;
        build_expected(0);
        do_transfer(0, 0, -1);
        checks++;
        if (timed_out) begin errors++; $display("FAIL zero_timeout: got no done, expected done"); end
        checks++;
        if (got_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL zero_len: got %0d beats expected %0d", got_data.size(), exp_data.size());
        end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL zero_beat%0d: got %h/%b expected %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL zero_done: got %0d pulses expected 1", n_done); end
        checks++;
        if (!prot_seen || out_lsdbuf_write_protect !== 1'b0) begin
            errors++;
            $display("FAIL zero_protect: got seen=%b final=%b expected 1/0", prot_seen, out_lsdbuf_write_protect);
        end
    endtask

    task automatic test_ready_wait();
        fill_mem();
        in_lsdbuf_line_num = AW'(2);
        build_expected(2);
        do_transfer(0, 10, 16);
        checks++;
        if (busy_early) begin errors++; $display("FAIL wait_early: got busy before buffer ready expected idle"); end
        checks++;
        if (timed_out || got_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL wait_len: got %0d beats expected %0d", got_data.size(), exp_data.size());
        end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL wait_beat%0d: got %h/%b expected %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        begin
            int stray;
            stray = 0;
            repeat (12) begin
                @(posedge clock); #1;
                if (out_busy || out_done || m_tvalid) stray++;
            end
            checks++;
            if (stray != 0) begin
                errors++;
                $display("FAIL wait_restart: got %0d active cycles after start-while-busy expected 0", stray);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k, got;
        bit seen2;
        fill_mem();
        in_lsdbuf_line_num = AW'(3);
        in_start = 1'b1; m_tready = 1'b1;
        k = 0; got = 0; seen2 = 0;
        while (!seen2 && k < 300) begin
            @(posedge clock); #1;
            k++;
            in_start = 1'b0;
            m_tready = (got == 0);
            if (m_tvalid && got == (HDR + 1)) seen2 = 1;
            else if (m_tvalid && m_tready) got++;
            if (got > 0 && got < HDR + 1) m_tready = 1'b1;
        end
        checks++;
        if (!seen2) begin errors++; $display("FAIL rstmid_timeout: got no 2nd beat expected one"); end
        n_rst = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || out_lsdbuf_write_protect !== 1'b0 || out_done !== 1'b0 || out_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_abort: got v=%b prot=%b done=%b busy=%b expected all 0",
                     m_tvalid, out_lsdbuf_write_protect, out_done, out_busy);
        end
        @(posedge clock); @(posedge clock); #1;
        n_rst = 1'b1;
        m_tready = 1'b1;
        @(posedge clock); #1;
        build_expected(3);
        do_transfer(0, 0, -1);
        checks++;
        if (timed_out || got_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL rstmid_len: got %0d beats expected %0d", got_data.size(), exp_data.size());
        end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL rstmid_beat%0d: got %h/%b expected %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(1, RS - 1);
            fill_mem();
            in_lsdbuf_line_num = AW'(n);
            build_expected(n);
            do_transfer(2, 0, -1);
            checks++;
            if (timed_out || got_data.size() != exp_data.size()) begin
                errors++;
                $display("FAIL rand%0d_len: got %0d beats expected %0d", r, got_data.size(), exp_data.size());
            end
            for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
                checks++;
                if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d: got %h/%b expected %h/%b", r, i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
                end
            end
            checks++;
            if (n_done != 1 || n_stall_viol != 0 || n_prot_viol != 0) begin
                errors++;
                $display("FAIL rand%0d_ctrl: got done=%0d hold=%0d prot=%0d expected 1/0/0", r, n_done, n_stall_viol, n_prot_viol);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < RS; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_ready_wait();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
